// File: rtl/pipe_pkg.sv
// Shared ISA constants for the ID-stage fetch-control block.
// Holds opcodes, PCsrc encodings, field positions, decode bundle.
package pipe_pkg;

  localparam logic [3:0] OP_LW   = 4'h5;
  localparam logic [3:0] OP_BEQ  = 4'h8;
  localparam logic [3:0] OP_BNE  = 4'h9;
  localparam logic [3:0] OP_J    = 4'hC;
  localparam logic [3:0] OP_CALL = 4'hD;
  localparam logic [3:0] OP_RET  = 4'hE;

  localparam logic [1:0] PCSRC_SEQ    = 2'd0;
  localparam logic [1:0] PCSRC_JUMP   = 2'd1;
  localparam logic [1:0] PCSRC_BRANCH = 2'd2;
  localparam logic [1:0] PCSRC_RET    = 2'd3;

  localparam int OP_HI    = 15;
  localparam int OP_LO    = 12;
  localparam int RS_HI    = 11;
  localparam int RS_LO    = 9;
  localparam int RT_HI    = 8;
  localparam int RT_LO    = 6;
  localparam int IMM6_HI  = 5;
  localparam int IMM12_HI = 11;

  typedef struct packed {
    logic j;
    logic call;
    logic ret;
    logic beq;
    logic bne;
    logic rd_rs;
    logic rd_rt;
  } dec_t;

endpackage

// File: rtl/return_address_stack.sv
// Circular return-address stack: push/pop, top, full/empty, sticky flags.
// Ports: clk, rst_n, push, pop, data -> top, full, empty, overflow, underflow.
module return_address_stack #(
  parameter int RAS_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic        pop,
  input  logic [15:0] data,
  output logic [15:0] top,
  output logic        full,
  output logic        empty,
  output logic        overflow,
  output logic        underflow
);

  localparam int RAS_PTR_W = $clog2(RAS_DEPTH);
  localparam logic [RAS_PTR_W:0] DEPTH_C =
    (RAS_PTR_W+1)'(RAS_DEPTH);

  logic [15:0]          ent [RAS_DEPTH];
  logic [RAS_PTR_W-1:0] ptr;
  logic [RAS_PTR_W-1:0] top_idx;
  logic [RAS_PTR_W:0]   cnt;

  assign top_idx = ptr - 1'b1;
  assign empty   = (cnt == '0);
  assign full    = (cnt == DEPTH_C);
  assign top     = empty ? 16'h0000 : ent[top_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      cnt       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++)
        ent[i] <= '0;
    end else if (push) begin
      // full stack wraps: the slot at ptr is the oldest entry
      ent[ptr] <= data;
      ptr      <= ptr + 1'b1;
      if (full) overflow <= 1'b1;
      else      cnt      <= cnt + 1'b1;
    end else if (pop) begin
      if (empty) begin
        underflow <= 1'b1;
      end else begin
        ptr <= top_idx;
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// ID-stage fetch control: decode, targets, RAS, hazard stall FSM.
// Ports: clk, rst_n, id_valid, inst_ID, npc_ID, rs_eq_rt, EX/MEM hazard
// inputs -> stall, kill, PCsrc, I/J targets, ReturnAddress, RAS flags.
// PC_REDIRECT_STATS_EN adds redirect_cnt / stall_cnt outputs.
module pc_redirect_ctrl
  import pipe_pkg::*;
#(
  parameter int RAS_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [15:0] inst_ID,
  input  logic [15:0] npc_ID,
  input  logic        rs_eq_rt,
  input  logic        ex_reg_write,
  input  logic        ex_is_load,
  input  logic [2:0]  ex_rd,
  input  logic        mem_is_load,
  input  logic [2:0]  mem_rd,
  output logic        stall,
  output logic        kill,
  output logic [1:0]  PCsrc,
  output logic [15:0] I_TypeImmediate,
  output logic [15:0] J_TypeImmediate,
  output logic [15:0] ReturnAddress,
`ifdef PC_REDIRECT_STATS_EN
  output logic [15:0] redirect_cnt,
  output logic [15:0] stall_cnt,
`endif
  output logic        ras_overflow,
  output logic        ras_underflow
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [0:0]  state;
  logic [1:0]  hold_cnt;
  logic [1:0]  need;
  logic [3:0]  op;
  logic [2:0]  rs, rt;
  logic        hit_ex, hit_mem;
  logic        stall_i;
  logic [1:0]  pcsrc_i;
  logic        push, pop;
  logic [15:0] ras_top;
  logic        ras_full, ras_empty;
  logic        unused_ras;
  logic [15:0] jt, it;
  dec_t        dec;

  assign op = inst_ID[OP_HI:OP_LO];
  assign rs = inst_ID[RS_HI:RS_LO];
  assign rt = inst_ID[RT_HI:RT_LO];

  assign jt = npc_ID +
    {{3{inst_ID[IMM12_HI]}}, inst_ID[IMM12_HI:0], 1'b0};
  assign it = npc_ID +
    {{9{inst_ID[IMM6_HI]}}, inst_ID[IMM6_HI:0], 1'b0};

  always_comb begin
    dec = '0;
    if (id_valid) begin
      unique case (1'b1)
        op == OP_J:    dec.j = 1'b1;
        op == OP_CALL: dec.call = 1'b1;
        op == OP_RET:  dec.ret = 1'b1;
        op == OP_BEQ: begin
          dec.beq   = 1'b1;
          dec.rd_rs = 1'b1;
          dec.rd_rt = 1'b1;
        end
        op == OP_BNE: begin
          dec.bne   = 1'b1;
          dec.rd_rs = 1'b1;
          dec.rd_rt = 1'b1;
        end
        // rt of a load is its destination
        op == OP_LW:   dec.rd_rs = 1'b1;
        default: begin
          dec.rd_rs = 1'b1;
          dec.rd_rt = 1'b1;
        end
      endcase
    end
  end

  assign hit_ex = (ex_rd != 3'd0) &&
    ((dec.rd_rs && rs == ex_rd) || (dec.rd_rt && rt == ex_rd));
  assign hit_mem = (mem_rd != 3'd0) &&
    ((dec.rd_rs && rs == mem_rd) || (dec.rd_rt && rt == mem_rd));

  // branches resolve in ID, so they wait for forwarded results too
  always_comb begin
    need = 2'd0;
    if (dec.beq || dec.bne) begin
      if (ex_is_load && hit_ex)
        need = 2'd2;
      else if ((ex_reg_write && hit_ex) ||
               (mem_is_load && hit_mem))
        need = 2'd1;
    end else if (ex_is_load && hit_ex) begin
      need = 2'd1;
    end
  end

  assign stall_i = (state == ST_HOLD) || (need != 2'd0);

  always_comb begin
    pcsrc_i = PCSRC_SEQ;
    if (!stall_i) begin
      unique case (1'b1)
        dec.j || dec.call:    pcsrc_i = PCSRC_JUMP;
        dec.ret:              pcsrc_i = PCSRC_RET;
        dec.beq && rs_eq_rt:  pcsrc_i = PCSRC_BRANCH;
        dec.bne && !rs_eq_rt: pcsrc_i = PCSRC_BRANCH;
        default:              pcsrc_i = PCSRC_SEQ;
      endcase
    end
  end

  assign push = !stall_i && dec.call;
  assign pop  = !stall_i && dec.ret;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_RUN;
      hold_cnt <= 2'd0;
    end else if (state == ST_RUN) begin
      if (need == 2'd2) begin
        state    <= ST_HOLD;
        hold_cnt <= need - 2'd1;
      end
    end else begin
      hold_cnt <= hold_cnt - 2'd1;
      if (hold_cnt <= 2'd1) state <= ST_RUN;
    end
  end

  return_address_stack #(
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .data      (npc_ID),
    .top       (ras_top),
    .full      (ras_full),
    .empty     (ras_empty),
    .overflow  (ras_overflow),
    .underflow (ras_underflow)
  );

  assign unused_ras = ras_full;

  // outputs are forced low while reset is held
  assign stall           = rst_n && stall_i;
  assign PCsrc           = rst_n ? pcsrc_i : PCSRC_SEQ;
  assign kill            = rst_n && (pcsrc_i != PCSRC_SEQ);
  assign I_TypeImmediate = rst_n ? it : 16'h0000;
  assign J_TypeImmediate = rst_n ? jt : 16'h0000;
  assign ReturnAddress   =
    (rst_n && !ras_empty) ? ras_top : 16'h0000;

`ifdef PC_REDIRECT_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_cnt <= 16'h0000;
      stall_cnt    <= 16'h0000;
    end else begin
      if (kill && redirect_cnt != 16'hFFFF)
        redirect_cnt <= redirect_cnt + 16'h0001;
      if (stall && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'h0001;
    end
  end
`endif

endmodule

// File: doc/pc_redirect_ctrl.md
Name: pc_redirect_ctrl

Overview:
Control-side counterpart of the fetch stage. It sits at the ID stage, decodes the instruction in ID and drives the fetch-control bus into IF: stall, kill, PCsrc, I_TypeImmediate, J_TypeImmediate and ReturnAddress. It also owns a circular return-address stack (RAS) for CALL/RET and a stall FSM for branch and load-use hazards.

Parameters:
RAS_DEPTH, 8, number of RAS entries (power of two, >=2)
RAS_PTR_W, $clog2(RAS_DEPTH), RAS pointer width (derived, not overridden)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  inst_ID holds a real instruction (0 = bubble, decode ignored)
inst_ID  in  16  instruction in ID: [15:12] opcode, [11:9] rs, [8:6] rt, [5:0] imm6, [11:0] imm12
npc_ID  in  16  address of instruction after inst_ID
rs_eq_rt  in  1  register-file compare result for inst_ID
ex_reg_write  in  1  EX instruction writes a register
ex_is_load  in  1  EX instruction is LW
ex_rd  in  3  EX destination register
mem_is_load  in  1  MEM instruction is LW
mem_rd  in  3  MEM destination register
stall  out  1  freeze PC/IF
kill  out  1  replace inst_IF with NOP this cycle
PCsrc  out  2  0 sequential, 1 J-target, 2 branch-target, 3 return
I_TypeImmediate  out  16  branch target
J_TypeImmediate  out  16  jump/call target
ReturnAddress  out  16  RAS top
ras_overflow  out  1  sticky: push while full
ras_underflow  out  1  sticky: pop while empty

Behaviour:
- Reset (async, rst_n=0): FSM=RUN, hold_cnt=0, RAS ptr=0, count=0, entries=0, sticky flags=0. While in reset all outputs = 0.
- Targets, continuous, modulo 2^16: J_TypeImmediate = npc_ID + (sext(imm12)<<1). I_TypeImmediate = npc_ID + (sext(imm6)<<1). ReturnAddress = RAS top entry, or 16'h0000 when empty.
- Decode, only when id_valid=1:
  - J: PCsrc=1.
  - CALL: PCsrc=1 and push npc_ID.
  - RET: PCsrc=3 and pop.
  - BEQ: PCsrc=2 if rs_eq_rt.
  - BNE: PCsrc=2 if !rs_eq_rt.
  - Any other opcode: PCsrc=0.
- kill = (PCsrc!=0) in the same cycle, combinational. The wrong-path instruction in IF is squashed on the same edge the PC is redirected.
- Hazard need (r0 never matches; rs/rt compared only for opcodes that read them):
  - BEQ/BNE/RET-free:
    - BEQ/BNE with EX load matching rs or rt: need=2.
    - BEQ/BNE with EX ALU write matching rs or rt: need=1.
    - BEQ/BNE with MEM load matching rs or rt: need=1.
    - Any other reader with EX load matching rs or rt: need=1.
    - Otherwise: need=0.
- Stall FSM:
  - RUN: if need>0, assert stall and go to HOLD with hold_cnt=need-1 when need=2; stay in RUN when need=1.
  - HOLD: stall=1 regardless of inputs; decrement hold_cnt; return to RUN when it reaches 0.
  - Every stalled cycle: PCsrc=0, kill=0, no push/pop. Stall has priority over redirect.
  - On leaving a stall, hazards are re-evaluated with fresh inputs.
- RAS is circular.
  - Push: write entry[ptr], ptr+1 mod DEPTH, count saturates at DEPTH.
  - Push at count=DEPTH: overwrite oldest and set ras_overflow.
  - Pop: ptr-1, count-1.
  - Pop at count=0: ReturnAddress=0, ptr/count unchanged, set ras_underflow.
  - Push and pop never occur in the same cycle (single ID instruction).
- Reset asserted mid-stall or mid-RAS update: immediate return to reset state; any pending push is lost.

Optional Feature:
PC_REDIRECT_STATS_EN
- Defined: adds outputs redirect_cnt[15:0] and stall_cnt[15:0]. Saturating counters, reset 0, increment once per cycle with kill=1 or stall=1 respectively.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package pipe_pkg holds:
  - Opcode constants: OP_LW=4'h5, OP_BEQ=4'h8, OP_BNE=4'h9, OP_J=4'hC, OP_CALL=4'hD, OP_RET=4'hE.
  - PCsrc constants: PCSRC_SEQ=0, PCSRC_JUMP=1, PCSRC_BRANCH=2, PCSRC_RET=3.
  - Instruction field position constants.
- One sub-module: return_address_stack (push/pop/data/top/full/empty/overflow/underflow), parameterised by RAS_DEPTH.

Test Plan:
- Reset, then J with imm12=12'h004, npc_ID=16'h0010 -> PCsrc=1, kill=1, J_TypeImmediate=16'h0018 in the same cycle.
- BEQ, rs_eq_rt=1, imm6=6'h3E, npc_ID=16'h0020 -> PCsrc=2, I_TypeImmediate=16'h001C, kill=1. Same with rs_eq_rt=0 -> PCsrc=0, kill=0.
- CALL at npc_ID=16'h0040, then RET -> ReturnAddress=16'h0040, PCsrc=3, kill=1, RAS empty afterwards. A second RET -> ReturnAddress=0, ras_underflow=1 (sticky).
- 9 CALLs (RAS_DEPTH=8) with npc 2,4,...,18, then 8 RETs -> returns 18 down to 4, ras_overflow=1.
- BEQ reading r3 with EX LW r3 -> stall=1 for exactly 2 cycles, PCsrc=0/kill=0 during stall, then resolves. ADD reading r3 with EX LW r3 -> 1 stall cycle. EX LW r0 -> no stall.
- Assert rst_n=0 in the middle of a 2-cycle stall -> stall, PCsrc and kill go 0 immediately, FSM=RUN, RAS cleared.
